program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
- Autonomous instruction sequencer for the Simple_CPU datapath.
- Replaces manual opcode switches plus the Execute button with a loadable program memory, a program counter and a run/step/halt FSM.
- Drives Opcode, Operand and a one-cycle ExecStrobe into the control/ALU/port datapath.
- Supports unconditional jumps and branches on the datapath ZF flag.

Parameters:
- ADDR_WIDTH, 4, program memory address width (depth = 2**ADDR_WIDTH); must be ≤ WIDTH_SWITCH_LENGTH.
- WIDTH_OPCODE, 4, datapath opcode width.
- WIDTH_SWITCH_LENGTH, 6, immediate/operand width.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- ProgWrite  in  1  program memory write enable.
- ProgAddr  in  ADDR_WIDTH  program write address.
- ProgData  in  2+WIDTH_OPCODE+WIDTH_SWITCH_LENGTH  instruction word (12 bits at defaults).
- Start  in  1  level-sampled; begins execution at address 0.
- StepMode  in  1  when 1, pause after every EXEC.
- Step  in  1  resumes from PAUSE.
- Abort  in  1  synchronous return to IDLE.
- ZF  in  1  datapath zero flag.
- Opcode  out  WIDTH_OPCODE  registered opcode to Control.
- Operand  out  WIDTH_SWITCH_LENGTH  registered immediate to Mux4 port 3.
- ExecStrobe  out  1  one-cycle execute pulse (datapath write qualifier).
- Pc  out  ADDR_WIDTH  current program counter.
- Busy  out  1  state not in {IDLE, HALTED}.
- Done  out  1  state == HALTED.

Behaviour:
- Instruction word fields: [11:10] seq-op, [9:6] opcode, [5:0] imm. Jump target = imm[ADDR_WIDTH-1:0].
- Seq-ops:
  - 00 EXEC: issue opcode/imm to the datapath.
  - 01 JMP: PC ← target.
  - 10 JZ: PC ← ZF ? target : PC+1.
  - 11 HALT: stop execution.
- Reset: state IDLE; PC, Opcode, Operand = 0; ExecStrobe, Busy, Done = 0. Memory contents are not reset.
- States: IDLE, FETCH, ISSUE, SETTLE, PAUSE, HALTED.
- IDLE / HALTED:
  - Start=1 → PC←0, Done←0, next state FETCH.
  - ProgWrite writes mem[ProgAddr] at the edge.
  - ProgWrite and Start in the same cycle: the write completes first, so FETCH reads the new data.
- FETCH: IR ← mem[PC]; → ISSUE.
- ISSUE, by seq-op:
  - EXEC: register Opcode, Operand and ExecStrobe=1; → SETTLE.
  - JMP: PC←target; → FETCH. No strobe; 2 cycles per jump.
  - JZ: ZF sampled this cycle; PC updated as defined above; → FETCH.
  - HALT: → HALTED. PC holds the HALT address.
- SETTLE:
  - ExecStrobe is high for exactly this cycle; cleared at the edge leaving SETTLE.
  - PC←PC+1, modulo 2**ADDR_WIDTH (wraps to 0 from the last address).
  - Next state: StepMode ? PAUSE : FETCH.
- PAUSE: Step=1 → FETCH. StepMode cleared while in PAUSE → FETCH.
- Latency:
  - EXEC = 3 cycles (FETCH, ISSUE, SETTLE).
  - First ExecStrobe is high in the 3rd cycle after the edge that samples Start.
  - ZF produced by an EXEC is valid by the ISSUE of any later instruction.
- Ignored inputs:
  - ProgWrite when Busy=1 is ignored; memory is unchanged.
  - Start while Busy is ignored.
  - Step outside PAUSE is ignored.
- Abort:
  - Highest priority among synchronous inputs. Any state → IDLE at the next edge.
  - ExecStrobe=0 at that edge.
  - PC is retained; Opcode and Operand hold their last values.
- Opcode and Operand hold the last issued values between strobes.
- Async reset mid-operation: immediate return to reset values; an in-flight strobe is truncated.

Decomposition:
- Package simple_cpu_pkg holds:
  - seq-op enum (SEQ_EXEC, SEQ_JMP, SEQ_JZ, SEQ_HALT);
  - state enum;
  - instruction field position constants;
  - instruction width constant.
- Sub-module sequencer_prog_mem: 2**ADDR_WIDTH × 12-bit array, synchronous write, asynchronous read, no reset.
- The FSM, PC, IR and output registers live in program_sequencer.

Test Plan:
- Load mem[0]=0x0C5, mem[1]=0xC00; pulse Start → exactly one ExecStrobe cycle, 3 cycles after Start, with Opcode=3 and Operand=5. Then Done=1, Busy=0, Pc=1.
- Load mem[0]=0x402, mem[2]=0xC00 → no strobe; HALTED with Pc=2 after 5 cycles.
- mem[0]=0x807, mem[1]=0xC00, mem[7]=0xC00:
  - ZF=1 → Pc=7 at HALT;
  - ZF=0 → Pc=1 at HALT.
- StepMode=1, program of three EXECs then HALT → FSM stops in PAUSE after each strobe. Each Step pulse yields exactly one further strobe. Step pulses in other states have no effect.
- Fill all 16 locations with EXEC → Pc wraps 15→0 and execution continues. Abort mid-SETTLE → IDLE next cycle with the Pc value retained.
- Assert ProgWrite while Busy → the memory word is unchanged on a later run. Assert Rst during ISSUE → all outputs 0 and state IDLE immediately.

Source files
------------

// File: rtl/simple_cpu_pkg.sv
// Shared types and constants for the Simple_CPU program sequencer.
package simple_cpu_pkg;

  localparam int unsigned SEQ_OP_WIDTH            = 2;
  localparam int unsigned DEF_ADDR_WIDTH          = 4;
  localparam int unsigned DEF_WIDTH_OPCODE        = 4;
  localparam int unsigned DEF_WIDTH_SWITCH_LENGTH = 6;

  // Instruction word layout at default widths: {seq_op, opcode, imm}
  localparam int unsigned INSTR_WIDTH = SEQ_OP_WIDTH + DEF_WIDTH_OPCODE + DEF_WIDTH_SWITCH_LENGTH;
  localparam int unsigned IMM_LSB     = 0;
  localparam int unsigned OPCODE_LSB  = IMM_LSB + DEF_WIDTH_SWITCH_LENGTH;
  localparam int unsigned SEQ_OP_LSB  = OPCODE_LSB + DEF_WIDTH_OPCODE;

  typedef enum logic [1:0] {
    SEQ_EXEC = 2'b00,
    SEQ_JMP  = 2'b01,
    SEQ_JZ   = 2'b10,
    SEQ_HALT = 2'b11
  } seq_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_SETTLE,
    ST_PAUSE,
    ST_HALTED
  } seq_state_t;

  // Instruction word width for arbitrary opcode/immediate widths
  function automatic int unsigned instr_width(int unsigned w_opcode, int unsigned w_imm);
    return SEQ_OP_WIDTH + w_opcode + w_imm;
  endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Host/datapath-facing signal bundle of the program sequencer.
interface program_sequencer_if
  import simple_cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH          = DEF_ADDR_WIDTH,
  parameter int unsigned WIDTH_OPCODE        = DEF_WIDTH_OPCODE,
  parameter int unsigned WIDTH_SWITCH_LENGTH = DEF_WIDTH_SWITCH_LENGTH
) ();

  localparam int unsigned IW = instr_width(WIDTH_OPCODE, WIDTH_SWITCH_LENGTH);

  logic                           ProgWrite;
  logic [ADDR_WIDTH-1:0]          ProgAddr;
  logic [IW-1:0]                  ProgData;
  logic                           Start;
  logic                           StepMode;
  logic                           Step;
  logic                           Abort;
  logic                           ZF;
  logic [WIDTH_OPCODE-1:0]        Opcode;
  logic [WIDTH_SWITCH_LENGTH-1:0] Operand;
  logic                           ExecStrobe;
  logic [ADDR_WIDTH-1:0]          Pc;
  logic                           Busy;
  logic                           Done;

  modport master (
    output ProgWrite, ProgAddr, ProgData, Start, StepMode, Step, Abort, ZF,
    input  Opcode, Operand, ExecStrobe, Pc, Busy, Done
  );

  modport slave (
    input  ProgWrite, ProgAddr, ProgData, Start, StepMode, Step, Abort, ZF,
    output Opcode, Operand, ExecStrobe, Pc, Busy, Done
  );

endinterface

// File: rtl/sequencer_prog_mem.sv
// Program store: synchronous write, asynchronous read, contents not reset.
module sequencer_prog_mem #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/program_sequencer.sv
// Run/step/halt instruction sequencer feeding opcode/operand and an execute pulse to the datapath.
module program_sequencer
  import simple_cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH          = DEF_ADDR_WIDTH,
  parameter int unsigned WIDTH_OPCODE        = DEF_WIDTH_OPCODE,
  parameter int unsigned WIDTH_SWITCH_LENGTH = DEF_WIDTH_SWITCH_LENGTH
) (
  input  logic               Clk,
  input  logic               Rst,
  program_sequencer_if.slave seq_bus
);

  localparam int unsigned IW      = instr_width(WIDTH_OPCODE, WIDTH_SWITCH_LENGTH);
  localparam int unsigned OPC_LSB = WIDTH_SWITCH_LENGTH;
  localparam int unsigned SEQ_LSB = WIDTH_SWITCH_LENGTH + WIDTH_OPCODE;

  seq_state_t                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]          pc_q, pc_d;
  logic [IW-1:0]                  ir_q, ir_d;
  logic [WIDTH_OPCODE-1:0]        opcode_q, opcode_d;
  logic [WIDTH_SWITCH_LENGTH-1:0] operand_q, operand_d;
  logic                           strobe_q, strobe_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;

  logic [IW-1:0]         mem_rdata;
  logic                  mem_we;
  seq_op_t               ir_op;
  logic [ADDR_WIDTH-1:0] target;

  assign ir_op  = seq_op_t'(ir_q[SEQ_LSB +: SEQ_OP_WIDTH]);
  assign target = ir_q[ADDR_WIDTH-1:0];
  // Program loads only land while the sequencer is not running
  assign mem_we = seq_bus.ProgWrite && (state_q == ST_IDLE || state_q == ST_HALTED);

  sequencer_prog_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (IW)
  ) u_prog_mem (
    .clk   (Clk),
    .we    (mem_we),
    .waddr (seq_bus.ProgAddr),
    .wdata (seq_bus.ProgData),
    .raddr (pc_q),
    .rdata (mem_rdata)
  );

  // State, PC, IR and output registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      opcode_q  <= '0;
      operand_q <= '0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and next-output logic; Abort overrides everything
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    strobe_d  = 1'b0;

    if (seq_bus.Abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALTED: begin
          if (seq_bus.Start) begin
            pc_d    = '0;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          ir_d    = mem_rdata;
          state_d = ST_ISSUE;
        end
        ST_ISSUE: begin
          case (ir_op)
            SEQ_EXEC: begin
              opcode_d  = ir_q[OPC_LSB +: WIDTH_OPCODE];
              operand_d = ir_q[WIDTH_SWITCH_LENGTH-1:0];
              strobe_d  = 1'b1;
              state_d   = ST_SETTLE;
            end
            SEQ_JMP: begin
              pc_d    = target;
              state_d = ST_FETCH;
            end
            SEQ_JZ: begin
              pc_d    = seq_bus.ZF ? target : pc_q + ADDR_WIDTH'(1);
              state_d = ST_FETCH;
            end
            SEQ_HALT: state_d = ST_HALTED;
            default:  state_d = ST_IDLE;
          endcase
        end
        ST_SETTLE: begin
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = seq_bus.StepMode ? ST_PAUSE : ST_FETCH;
        end
        ST_PAUSE: begin
          if (seq_bus.Step || !seq_bus.StepMode) state_d = ST_FETCH;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = !(state_d == ST_IDLE || state_d == ST_HALTED);
    done_d = (state_d == ST_HALTED);
  end

  assign seq_bus.Opcode     = opcode_q;
  assign seq_bus.Operand    = operand_q;
  assign seq_bus.ExecStrobe = strobe_q;
  assign seq_bus.Pc         = pc_q;
  assign seq_bus.Busy       = busy_q;
  assign seq_bus.Done       = done_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Testbench for program_sequencer: directed scenarios plus random forward-branching programs.
module tb_program_sequencer;

  typedef struct {
    int off;
    int op;
    int imm;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  program_sequencer_if #(.ADDR_WIDTH(4), .WIDTH_OPCODE(4), .WIDTH_SWITCH_LENGTH(6)) bus ();

  program_sequencer #(.ADDR_WIDTH(4), .WIDTH_OPCODE(4), .WIDTH_SWITCH_LENGTH(6)) dut (
    .Clk     (clk),
    .Rst     (rst),
    .seq_bus (bus)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic zf_mode = 1'b0;
  logic zf_force = 1'b0;
  logic zf_last = 1'b0;
  assign bus.ZF = zf_mode ? zf_last : zf_force;

  int ncyc = 0;
  int start_n = 0;
  int done_off = -1;
  ev_t act[$];
  ev_t exp_q[$];
  int exp_halt;
  int exp_pc;
  logic [11:0] shadow [16];

  // Observer: strobe log, Done timing and a datapath-like ZF (operand==0 of last strobe)
  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (bus.ExecStrobe) begin
      act.push_back('{ncyc - start_n, int'(bus.Opcode), int'(bus.Operand)});
      zf_last <= (bus.Operand == 6'd0);
    end
    if (bus.Done && done_off < 0) done_off <= ncyc - start_n;
    if (bus.Start && !bus.Busy && !rst) begin
      start_n  <= ncyc;
      done_off <= -1;
      zf_last  <= 1'b0;
      act.delete();
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int addr, input logic [11:0] data);
    bus.ProgWrite = 1'b1;
    bus.ProgAddr  = 4'(addr);
    bus.ProgData  = data;
    tick();
    bus.ProgWrite = 1'b0;
    shadow[addr]  = data;
  endtask

  task automatic start_pulse();
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
  endtask

  task automatic run_to_done(output bit timed_out);
    int b = 0;
    while (!bus.Done && b < 400) begin
      tick();
      b++;
    end
    timed_out = !bus.Done;
    tick();
  endtask

  task automatic wait_strobes(input int k);
    int b = 0;
    while (act.size() < k && b < 60) begin
      tick();
      b++;
    end
  endtask

  // Program-level reference: walks the shadow memory and times each instruction
  task automatic model_run(input bit zmode, input bit zforce);
    int pc = 0;
    int t = 0;
    bit z;
    bit halted = 0;
    logic [11:0] w;
    exp_q.delete();
    exp_halt = -1;
    exp_pc = -1;
    z = zmode ? 1'b0 : zforce;
    for (int n = 0; n < 64 && !halted; n++) begin
      w = shadow[pc];
      case (w[11:10])
        2'd0: begin
          exp_q.push_back('{t + 3, int'(w[9:6]), int'(w[5:0])});
          if (zmode) z = (w[5:0] == 6'd0);
          pc = (pc + 1) % 16;
          t += 3;
        end
        2'd1: begin
          pc = int'(w[3:0]);
          t += 2;
        end
        2'd2: begin
          pc = z ? int'(w[3:0]) : (pc + 1) % 16;
          t += 2;
        end
        default: begin
          exp_halt = t + 3;
          exp_pc = pc;
          halted = 1;
        end
      endcase
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ProgWrite = 1'b0; bus.ProgAddr = '0; bus.ProgData = '0;
    bus.Start = 1'b0; bus.StepMode = 1'b0; bus.Step = 1'b0; bus.Abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if ({bus.Opcode, bus.Operand, bus.ExecStrobe, bus.Pc, bus.Busy, bus.Done} !== 17'd0) begin
      $display("FAIL reset_outputs: got op=%0d opd=%0d stb=%0b pc=%0d busy=%0b done=%0b want all 0",
               bus.Opcode, bus.Operand, bus.ExecStrobe, bus.Pc, bus.Busy, bus.Done);
    end else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_exec_halt();
    bit to;
    load_word(0, 12'h0C5);
    load_word(1, 12'hC00);
    start_pulse();
    run_to_done(to);
    chk_cnt++;
    if (to || act.size() != 1) $display("FAIL exec_strobe_count: got %0d want 1 (timeout=%0b)", act.size(), to);
    else pass_cnt++;
    chk_cnt++;
    if (act.size() < 1 || act[0].off != 3 || act[0].op != 3 || act[0].imm != 5)
      $display("FAIL exec_strobe_fields: got off=%0d op=%0d imm=%0d want 3/3/5",
               act.size() ? act[0].off : -1, act.size() ? act[0].op : -1, act.size() ? act[0].imm : -1);
    else pass_cnt++;
    chk_cnt++;
    if (bus.Done !== 1'b1 || bus.Busy !== 1'b0 || bus.Pc !== 4'd1)
      $display("FAIL exec_halt_state: got done=%0b busy=%0b pc=%0d want 1/0/1", bus.Done, bus.Busy, bus.Pc);
    else pass_cnt++;
  endtask

  task automatic test_jmp();
    bit to;
    load_word(0, 12'h402);
    load_word(1, 12'h0C5);
    load_word(2, 12'hC00);
    start_pulse();
    run_to_done(to);
    chk_cnt++;
    if (to || act.size() != 0 || done_off != 5 || bus.Pc !== 4'd2)
      $display("FAIL jmp_halt: got strobes=%0d done_off=%0d pc=%0d want 0/5/2", act.size(), done_off, bus.Pc);
    else pass_cnt++;
  endtask

  task automatic test_jz();
    bit to;
    load_word(0, 12'h807);
    load_word(1, 12'hC00);
    load_word(7, 12'hC00);
    for (int z = 1; z >= 0; z--) begin
      zf_mode = 1'b0;
      zf_force = 1'(z);
      start_pulse();
      run_to_done(to);
      chk_cnt++;
      if (to || bus.Pc !== (z ? 4'd7 : 4'd1) || done_off != 5)
        $display("FAIL jz_zf%0d: got pc=%0d done_off=%0d want pc=%0d done_off=5", z, bus.Pc, done_off, z ? 7 : 1);
      else pass_cnt++;
    end
    zf_force = 1'b0;
  endtask

  task automatic test_step_mode();
    bit to;
    load_word(0, 12'h041);
    load_word(1, 12'h082);
    load_word(2, 12'h0C3);
    load_word(3, 12'hC00);
    bus.StepMode = 1'b1;
    start_pulse();
    for (int k = 1; k <= 3; k++) begin
      wait_strobes(k);
      repeat (6) tick();
      chk_cnt++;
      if (act.size() != k || bus.Busy !== 1'b1 || bus.Done !== 1'b0)
        $display("FAIL step_pause_%0d: got strobes=%0d busy=%0b done=%0b want %0d/1/0", k, act.size(), bus.Busy, bus.Done, k);
      else pass_cnt++;
      // One Step sampled in PAUSE, a second one sampled in FETCH that must be ignored
      bus.Step = 1'b1;
      tick();
      tick();
      bus.Step = 1'b0;
    end
    run_to_done(to);
    chk_cnt++;
    if (to || act.size() != 3 || bus.Pc !== 4'd3 ||
        act[0].op != 1 || act[1].op != 2 || act[2].op != 3 || act[2].imm != 3)
      $display("FAIL step_finish: got strobes=%0d pc=%0d timeout=%0b want 3 strobes ops 1,2,3 pc=3", act.size(), bus.Pc, to);
    else pass_cnt++;
    bus.Step = 1'b1;
    tick();
    bus.Step = 1'b0;
    repeat (3) tick();
    chk_cnt++;
    if (bus.Done !== 1'b1 || bus.Busy !== 1'b0 || act.size() != 3)
      $display("FAIL step_in_halted: got done=%0b busy=%0b strobes=%0d want 1/0/3", bus.Done, bus.Busy, act.size());
    else pass_cnt++;
    bus.StepMode = 1'b0;
  endtask

  task automatic test_wrap_abort();
    int b = 0;
    bit ok = 1;
    for (int i = 0; i < 16; i++) load_word(i, {2'b00, 4'(i), 6'(i + 16)});
    start_pulse();
    while (!(bus.ExecStrobe && act.size() == 19) && b < 200) begin
      tick();
      b++;
    end
    bus.Abort = 1'b1;
    tick();
    bus.Abort = 1'b0;
    chk_cnt++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.ExecStrobe !== 1'b0 || bus.Pc !== 4'd3)
      $display("FAIL abort_state: got busy=%0b done=%0b stb=%0b pc=%0d want 0/0/0/3", bus.Busy, bus.Done, bus.ExecStrobe, bus.Pc);
    else pass_cnt++;
    chk_cnt++;
    if (bus.Opcode !== 4'd3 || bus.Operand !== 6'd19)
      $display("FAIL abort_hold: got op=%0d opd=%0d want 3/19", bus.Opcode, bus.Operand);
    else pass_cnt++;
    for (int k = 0; k < act.size(); k++) if (act[k].imm != (k % 16) + 16 || act[k].off != 3 + 3 * k) ok = 0;
    chk_cnt++;
    if (!ok || act.size() != 20) $display("FAIL wrap_sequence: got strobes=%0d order_ok=%0b want 20/1", act.size(), ok);
    else pass_cnt++;
    repeat (4) tick();
    chk_cnt++;
    if (act.size() != 20 || bus.Busy !== 1'b0) $display("FAIL abort_idle: got strobes=%0d busy=%0b want 20/0", act.size(), bus.Busy);
    else pass_cnt++;
  endtask

  task automatic test_busy_write();
    bit to;
    load_word(0, 12'h149);
    load_word(1, 12'h18A);
    load_word(2, 12'hC00);
    start_pulse();
    bus.ProgWrite = 1'b1;
    bus.ProgAddr = 4'd0;
    bus.ProgData = 12'h3FF;
    bus.Start = 1'b1;
    tick();
    bus.ProgWrite = 1'b0;
    bus.Start = 1'b0;
    run_to_done(to);
    chk_cnt++;
    if (to || act.size() != 2 || done_off != 9)
      $display("FAIL busy_start_ignored: got strobes=%0d done_off=%0d want 2/9", act.size(), done_off);
    else pass_cnt++;
    start_pulse();
    run_to_done(to);
    chk_cnt++;
    if (to || act.size() < 1 || act[0].op != 5 || act[0].imm != 9)
      $display("FAIL busy_write_ignored: got op=%0d imm=%0d want 5/9",
               act.size() ? act[0].op : -1, act.size() ? act[0].imm : -1);
    else pass_cnt++;
  endtask

  task automatic test_write_with_start();
    bit to;
    bus.ProgWrite = 1'b1;
    bus.ProgAddr = 4'd0;
    bus.ProgData = 12'h1E1;
    bus.Start = 1'b1;
    shadow[0] = 12'h1E1;
    tick();
    bus.ProgWrite = 1'b0;
    bus.Start = 1'b0;
    run_to_done(to);
    chk_cnt++;
    if (to || act.size() < 1 || act[0].op != 7 || act[0].imm != 33)
      $display("FAIL write_start_same_cycle: got op=%0d imm=%0d want 7/33",
               act.size() ? act[0].op : -1, act.size() ? act[0].imm : -1);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    load_word(0, 12'h405);
    load_word(5, 12'h24C);
    load_word(6, 12'hC00);
    start_pulse();
    repeat (3) tick();
    chk_cnt++;
    if (bus.Pc !== 4'd5 || bus.Busy !== 1'b1) $display("FAIL pre_reset_pc: got pc=%0d busy=%0b want 5/1", bus.Pc, bus.Busy);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if ({bus.Opcode, bus.Operand, bus.ExecStrobe, bus.Pc, bus.Busy, bus.Done} !== 17'd0)
      $display("FAIL reset_mid_outputs: got op=%0d opd=%0d stb=%0b pc=%0d busy=%0b done=%0b want all 0",
               bus.Opcode, bus.Operand, bus.ExecStrobe, bus.Pc, bus.Busy, bus.Done);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk_cnt++;
    if (act.size() != 0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0)
      $display("FAIL reset_mid_idle: got strobes=%0d busy=%0b done=%0b want 0/0/0", act.size(), bus.Busy, bus.Done);
    else pass_cnt++;
  endtask

  task automatic test_random();
    bit to;
    int s, o, i;
    for (int r = 0; r < 20; r++) begin
      for (int a = 0; a < 16; a++) begin
        s = (a == 15) ? 9 : int'($urandom_range(0, 9));
        o = int'($urandom_range(0, 15));
        if (s <= 5) begin
          i = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 63));
          s = 0;
        end else if (s <= 8) begin
          i = int'($urandom_range(0, 3)) * 16 + int'($urandom_range(a + 1, 15));
          s = (s == 6) ? 1 : 2;
        end else begin
          i = int'($urandom_range(0, 63));
          s = 3;
        end
        load_word(a, {2'(s), 4'(o), 6'(i)});
      end
      zf_mode = 1'($urandom_range(0, 1));
      zf_force = 1'($urandom_range(0, 1));
      model_run(zf_mode, zf_force);
      start_pulse();
      run_to_done(to);
      chk_cnt++;
      if (to || act.size() != exp_q.size())
        $display("FAIL rand%0d_count: got %0d strobes want %0d (timeout=%0b)", r, act.size(), exp_q.size(), to);
      else pass_cnt++;
      for (int k = 0; k < act.size() && k < exp_q.size(); k++) begin
        chk_cnt++;
        if (act[k] != exp_q[k])
          $display("FAIL rand%0d_strobe%0d: got off=%0d op=%0d imm=%0d want off=%0d op=%0d imm=%0d",
                   r, k, act[k].off, act[k].op, act[k].imm, exp_q[k].off, exp_q[k].op, exp_q[k].imm);
        else pass_cnt++;
      end
      chk_cnt++;
      if (done_off != exp_halt || int'(bus.Pc) != exp_pc)
        $display("FAIL rand%0d_halt: got done_off=%0d pc=%0d want %0d/%0d", r, done_off, bus.Pc, exp_halt, exp_pc);
      else pass_cnt++;
      if (exp_q.size() > 0) begin
        chk_cnt++;
        if (int'(bus.Opcode) != exp_q[$].op || int'(bus.Operand) != exp_q[$].imm)
          $display("FAIL rand%0d_hold: got op=%0d opd=%0d want %0d/%0d", r, bus.Opcode, bus.Operand, exp_q[$].op, exp_q[$].imm);
        else pass_cnt++;
      end
    end
    zf_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_exec_halt();
    test_jmp();
    test_jz();
    test_step_mode();
    test_wrap_abort();
    test_busy_write();
    test_write_with_start();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
